// File: rtl/timer555_ctrl.sv
// timer555_ctrl: digital controller for a 555-style timer (monostable, astable, gated astable)
// with per-phase watchdog and saturating period counter. Optional macro: TIMER555_RETRIG_EN.
module timer555_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDOG_W      = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              trig,
  input  logic              cmp_trig,
  input  logic              cmp_thr,
  input  logic [WDOG_W-1:0] timeout,
  output logic              out,
  output logic              dis,
  output logic              busy,
  output logic              fault,
  output logic [CNT_W-1:0]  cycles
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_MONO    = 2'b01,
    MODE_ASTABLE = 2'b10,
    MODE_GATED   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_DISCHARGE = 3'd2,
    ST_FAULT     = 3'd3
`ifdef TIMER555_RETRIG_EN
    , ST_RETRIG  = 3'd4
`endif
  } state_e;

  state_e            state;
  state_e            state_nxt;
  mode_e             mode_v;
  logic [SS-1:0]     sync_ct;
  logic [SS-1:0]     sync_th;
  logic [SS-1:0]     sync_tr;
  logic              cmp_trig_s;
  logic              cmp_thr_s;
  logic              trig_s;
  logic              trig_prev;
  logic              trig_edge;
  logic [WDOG_W-1:0] wdog;
  logic              timing;
  logic              contention;
  logic              wdog_trip;
  logic              force_idle;
  logic              period_done;
  logic              out_nxt;
  logic              dis_nxt;

  assign mode_v     = mode_e'(mode);
  assign cmp_trig_s = sync_ct[SS-1];
  assign cmp_thr_s  = sync_th[SS-1];
  assign trig_s     = sync_tr[SS-1];
  assign trig_edge  = trig_s & ~trig_prev;
  assign force_idle = ~en | (mode_v == MODE_OFF);

  // States in which the capacitor is actively timing and the watchdog runs.
  always_comb begin
    timing = (state == ST_CHARGE) || (state == ST_DISCHARGE);
`ifdef TIMER555_RETRIG_EN
    timing = timing || (state == ST_RETRIG);
`endif
  end

  assign contention = ((state == ST_CHARGE) || (state == ST_DISCHARGE)) && cmp_trig_s && cmp_thr_s;
  assign wdog_trip  = timing && (timeout != '0) && (wdog == timeout - WDOG_W'(1));

  always_comb begin
    state_nxt   = state;
    period_done = 1'b0;
    if (force_idle) begin
      state_nxt = ST_IDLE;
    end else if (contention || wdog_trip) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((mode_v == MODE_MONO && trig_edge) ||
              (mode_v == MODE_ASTABLE) ||
              (mode_v == MODE_GATED && trig_s)) begin
            state_nxt = ST_CHARGE;
          end
        end
        ST_CHARGE: begin
`ifdef TIMER555_RETRIG_EN
          if (mode_v == MODE_MONO && trig_edge) begin
            state_nxt = ST_RETRIG;
          end else
`endif
          if (cmp_thr_s) begin
            if (mode_v == MODE_MONO) begin
              state_nxt   = ST_IDLE;
              period_done = 1'b1;
            end else begin
              state_nxt = ST_DISCHARGE;
            end
          end
        end
        ST_DISCHARGE: begin
          if (cmp_trig_s) begin
            period_done = 1'b1;
            state_nxt   = (mode_v == MODE_GATED && !trig_s) ? ST_IDLE : ST_CHARGE;
          end
        end
`ifdef TIMER555_RETRIG_EN
        ST_RETRIG: begin
          if (cmp_trig_s) begin
            state_nxt = ST_CHARGE;
          end
        end
`endif
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they always equal the decode of the state register.
  always_comb begin
    out_nxt = 1'b0;
    dis_nxt = 1'b1;
    case (state_nxt)
      ST_CHARGE: begin
        out_nxt = 1'b1;
        dis_nxt = 1'b0;
      end
`ifdef TIMER555_RETRIG_EN
      ST_RETRIG: begin
        out_nxt = 1'b1;
        dis_nxt = 1'b1;
      end
`endif
      default: begin
        out_nxt = 1'b0;
        dis_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ct   <= '0;
      sync_th   <= '0;
      sync_tr   <= '0;
      trig_prev <= 1'b0;
      state     <= ST_IDLE;
      wdog      <= '0;
      cycles    <= '0;
      out       <= 1'b0;
      dis       <= 1'b1;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      sync_ct   <= {sync_ct[SS-2:0], cmp_trig};
      sync_th   <= {sync_th[SS-2:0], cmp_thr};
      sync_tr   <= {sync_tr[SS-2:0], trig};
      trig_prev <= trig_s;
      state     <= state_nxt;

      if (state_nxt != state) begin
        wdog <= '0;
      end else if (timing) begin
        wdog <= wdog + WDOG_W'(1);
      end

      if (force_idle) begin
        cycles <= '0;
      end else if (period_done && (cycles != '1)) begin
        cycles <= cycles + CNT_W'(1);
      end

      out   <= out_nxt;
      dis   <= dis_nxt;
      busy  <= (state_nxt != ST_IDLE);
      fault <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_timer555_ctrl.sv
// Self-checking bench for timer555_ctrl: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model (default and CNT_W=2 instances).
module tb_timer555_ctrl;

  localparam int unsigned SS = 2;
  localparam int unsigned WW = 16;
`ifdef TIMER555_RETRIG_EN
  localparam bit RETRIG_ON = 1'b1;
`else
  localparam bit RETRIG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, trig, cmp_trig, cmp_thr;
  logic [1:0]    mode;
  logic [WW-1:0] timeout;
  logic          out, dis, busy, fault;
  logic [7:0]    cycles;
  logic          s_out, s_dis, s_busy, s_fault;
  logic [1:0]    s_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer555_ctrl #(.SYNC_STAGES(SS), .WDOG_W(WW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig),
    .cmp_trig(cmp_trig), .cmp_thr(cmp_thr), .timeout(timeout),
    .out(out), .dis(dis), .busy(busy), .fault(fault), .cycles(cycles)
  );

  timer555_ctrl #(.SYNC_STAGES(SS), .WDOG_W(WW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig),
    .cmp_trig(cmp_trig), .cmp_thr(cmp_thr), .timeout(timeout),
    .out(s_out), .dis(s_dis), .busy(s_busy), .fault(s_fault), .cycles(s_cycles)
  );

  // Behavioural reference: synchronizers as delay queues, phase length as a plain count.
  typedef enum int {M_IDLE, M_CHARGE, M_DISCH, M_FAULT, M_RETRIG} mstate_t;
  mstate_t ms;
  int      m_len;
  int      m_cyc;
  bit      m_prev;
  bit      q_ct[$];
  bit      q_th[$];
  bit      q_tr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms     = M_IDLE;
    m_len  = 0;
    m_cyc  = 0;
    m_prev = 1'b0;
    q_ct.delete();
    q_th.delete();
    q_tr.delete();
    for (int i = 0; i < int'(SS); i++) begin
      q_ct.push_back(1'b0);
      q_th.push_back(1'b0);
      q_tr.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit      ct_s, th_s, tr_s, tr_rise, done, in_phase;
    mstate_t nx;
    if (rst) begin
      model_reset();
      return;
    end
    ct_s = q_ct[0];
    th_s = q_th[0];
    tr_s = q_tr[0];
    void'(q_ct.pop_front());
    void'(q_th.pop_front());
    void'(q_tr.pop_front());
    q_ct.push_back(cmp_trig);
    q_th.push_back(cmp_thr);
    q_tr.push_back(trig);
    tr_rise  = tr_s && !m_prev;
    m_prev   = tr_s;
    nx       = ms;
    done     = 1'b0;
    in_phase = (ms == M_CHARGE) || (ms == M_DISCH) || (ms == M_RETRIG);
    if (!en || mode == 2'd0) begin
      nx    = M_IDLE;
      m_cyc = 0;
    end else if ((ms == M_CHARGE || ms == M_DISCH) && ct_s && th_s) begin
      nx = M_FAULT;
    end else if (in_phase && timeout != 0 && m_len == int'(timeout) - 1) begin
      nx = M_FAULT;
    end else begin
      case (ms)
        M_IDLE:
          if ((mode == 2'd1 && tr_rise) || mode == 2'd2 || (mode == 2'd3 && tr_s)) nx = M_CHARGE;
        M_CHARGE:
          if (RETRIG_ON && mode == 2'd1 && tr_rise) nx = M_RETRIG;
          else if (th_s) begin
            if (mode == 2'd1) begin nx = M_IDLE; done = 1'b1; end
            else nx = M_DISCH;
          end
        M_DISCH:
          if (ct_s) begin
            done = 1'b1;
            nx   = (mode == 2'd3 && !tr_s) ? M_IDLE : M_CHARGE;
          end
        M_RETRIG:
          if (ct_s) nx = M_CHARGE;
        default: nx = ms;
      endcase
      if (done) m_cyc++;
    end
    m_len = (nx != ms) ? 0 : m_len + 1;
    ms    = nx;
  endtask

  task automatic tick();
    int e_out, e_dis, e_busy, e_fault;
    @(posedge clk);
    model_step();
    #1;
    e_out   = (ms == M_CHARGE || ms == M_RETRIG) ? 1 : 0;
    e_dis   = (ms == M_CHARGE) ? 0 : 1;
    e_busy  = (ms != M_IDLE) ? 1 : 0;
    e_fault = (ms == M_FAULT) ? 1 : 0;
    check("out", out, e_out);
    check("dis", dis, e_dis);
    check("busy", busy, e_busy);
    check("fault", fault, e_fault);
    check("cycles", cycles, (m_cyc > 255) ? 255 : m_cyc);
    check("sat_out", s_out, e_out);
    check("sat_dis", s_dis, e_dis);
    check("sat_busy", s_busy, e_busy);
    check("sat_fault", s_fault, e_fault);
    check("sat_cycles", s_cycles, (m_cyc > 3) ? 3 : m_cyc);
  endtask

  task automatic wait_out(input logic want, input int limit, input string tag);
    int n = 0;
    while (out !== want && n < limit) begin
      tick();
      n++;
    end
    check(tag, out, want);
  endtask

  initial begin
    int hi, n;
    rst = 1'b1; en = 1'b0; mode = 2'b00; trig = 1'b0;
    cmp_trig = 1'b0; cmp_thr = 1'b0; timeout = '0;
    tick(); tick();
    check("rst_out", out, 0);
    check("rst_dis", dis, 1);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_cycles", cycles, 0);

    // Monostable: trig pulse, cmp_thr 50 cycles later.
    rst = 1'b0; en = 1'b1; mode = 2'b01;
    tick(); tick();
    check("mono_idle_busy", busy, 0);
    trig = 1'b1;
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) trig = 1'b0;
      if (i == 50) cmp_thr = 1'b1;
      tick();
      if (out === 1'b1) hi++;
    end
    cmp_thr = 1'b0;
    check("mono_high_len", hi, 50);
    check("mono_end_out", out, 0);
    check("mono_end_dis", dis, 1);
    check("mono_end_busy", busy, 0);
    check("mono_end_cycles", cycles, 1);
    repeat (4) tick();

    // Retrigger during CHARGE.
    trig = 1'b1;
    repeat (5) tick();
    trig = 1'b0;
    repeat (10) tick();
    check("retrig_pre_out", out, 1);
    trig = 1'b1;
    repeat (4) tick();
    check("retrig_out", out, 1);
    check("retrig_dis", dis, RETRIG_ON ? 1 : 0);
    check("retrig_busy", busy, 1);
    cmp_trig = 1'b1;
    repeat (4) tick();
    check("retrig_back_dis", dis, 0);
    check("retrig_back_out", out, 1);
    cmp_trig = 1'b0; trig = 1'b0;
    repeat (4) tick();
    cmp_thr = 1'b1;
    repeat (5) tick();
    cmp_thr = 1'b0;
    check("retrig_end_busy", busy, 0);
    check("retrig_end_cycles", cycles, 2);
    en = 1'b0;
    tick();
    check("disable_clears_cycles", cycles, 0);

    // Astable, five periods: default counter reaches 5, CNT_W=2 saturates at 3.
    mode = 2'b10; en = 1'b1;
    for (int p = 0; p < 5; p++) begin
      wait_out(1'b1, 20, "astable_rise");
      repeat ($urandom_range(5, 15)) tick();
      cmp_thr = 1'b1;
      wait_out(1'b0, 10, "astable_fall");
      check("astable_dis_low_phase", dis, 1);
      cmp_thr = 1'b0;
      repeat ($urandom_range(5, 15)) tick();
      cmp_trig = 1'b1;
      wait_out(1'b1, 10, "astable_recharge");
      check("astable_dis_high_phase", dis, 0);
      cmp_trig = 1'b0;
      if (p == 2) begin
        check("astable_cycles3", cycles, 3);
        check("astable_sat_cycles3", s_cycles, 3);
      end
    end
    check("astable_cycles5", cycles, 5);
    check("astable_sat_hold", s_cycles, 3);

    // Reset in the middle of CHARGE.
    repeat (3) tick();
    check("midcharge_out", out, 1);
    rst = 1'b1;
    tick();
    check("midrst_out", out, 0);
    check("midrst_dis", dis, 1);
    check("midrst_busy", busy, 0);
    check("midrst_fault", fault, 0);
    check("midrst_cycles", cycles, 0);
    check("midrst_sat_cycles", s_cycles, 0);
    rst = 1'b0;

    // Watchdog: 100 cycles in CHARGE with comparators held low.
    en = 1'b0;
    tick();
    timeout = WW'(100); en = 1'b1;
    hi = 0; n = 0;
    while (fault !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (out === 1'b1) hi++;
    end
    check("wdog_high_len", hi, 100);
    check("wdog_fault", fault, 1);
    check("wdog_out", out, 0);
    check("wdog_dis", dis, 1);
    en = 1'b0;
    tick();
    check("wdog_clear_fault", fault, 0);
    check("wdog_clear_busy", busy, 0);
    timeout = '0;

    // Comparator contention in CHARGE.
    en = 1'b1;
    repeat (4) tick();
    cmp_trig = 1'b1; cmp_thr = 1'b1;
    n = 0;
    while (fault !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("contention_latency", n, SS + 1);
    cmp_trig = 1'b0; cmp_thr = 1'b0;
    repeat (10) tick();
    check("fault_held", fault, 1);
    mode = 2'b00;
    tick();
    check("fault_release", fault, 0);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) trig = ~trig;
      if ($urandom_range(0, 11) == 0) cmp_thr = ~cmp_thr;
      if ($urandom_range(0, 11) == 0) cmp_trig = ~cmp_trig;
      if ($urandom_range(0, 299) == 0)
        timeout = ($urandom_range(0, 2) == 0) ? '0 : WW'($urandom_range(3, 60));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
